// File: rtl/mainfsm_ws_pkg.sv
// Shared encodings for the wait-state main control FSM: states, mux selects, Op field.
package mainfsm_ws_pkg;

    localparam int unsigned STATE_W = 4;

    // State encodings are visible on the debug State port, so values are fixed.
    typedef enum logic [STATE_W-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StExecuteM = 4'd10,
        StFault    = 4'd11
    } state_e;

    // ResultSrc selects
    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_REG     = 2'b00;
    localparam logic [1:0] SRCA_PC      = 2'b01;
    localparam logic [1:0] SRCA_ALU_OUT = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Op field
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // States that hold a memory access open until MemReady.
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mainfsm_ws_wait_counter.sv
// Clearable up-counter with a terminal-value compare; shared by memory timeout and multiply.
module mainfsm_ws_wait_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so a state change always restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term);

endmodule

// File: rtl/mainfsm_ws.sv
// Multicycle main control FSM with memory handshake, wait-state timeout and iterative multiply.
module mainfsm_ws
    import mainfsm_ws_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned SUPPORT_MUL = 1,
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       IsMul,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       MulBusy,
    output logic       Fault,
    output logic [3:0] State
);

    localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic MUL_EN     = (SUPPORT_MUL != 0);

    state_e           state_q;
    state_e           state_d;
    logic             wait_state;
    logic             timeout_hit;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             at_term;
    logic [CNT_W-1:0] cnt_term;
    logic             unused_funct;

    // Funct[4:1] belong to the ALU decoder, not to sequencing.
    assign unused_funct = ^Funct[4:1];

    // State register; reset abandons any access or multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign wait_state  = is_wait_state(state_q);
    assign cnt_term    = (state_q == StExecuteM) ? MUL_TERM : TIMEOUT_TERM;
    assign timeout_hit = TIMEOUT_EN && wait_state && !MemReady && at_term;
    assign cnt_clr     = (state_d != state_q);
    assign cnt_inc     = (wait_state && !MemReady) || (state_q == StExecuteM);

    mainfsm_ws_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .term    (cnt_term),
        .at_term (at_term)
    );

    // Next-state logic; timeout overrides a stall but never a completing access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (MemReady) state_d = StDecode;
            end
            StDecode: begin
                case (Op)
                    OP_DP: begin
                        if (Funct[5]) begin
                            state_d = StExecuteI;
                        end else if (IsMul && MUL_EN) begin
                            state_d = StExecuteM;
                        end else begin
                            state_d = StExecuteR;
                        end
                    end
                    OP_MEM:    state_d = StMemAdr;
                    OP_BRANCH: state_d = StBranch;
                    default:   state_d = StFault;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemWrite : StMemRead;
            StMemRead: begin
                if (MemReady) state_d = StMemWb;
            end
            StMemWrite: begin
                if (MemReady) state_d = StFetch;
            end
            StMemWb, StAluWb, StBranch: state_d = StFetch;
            StExecuteR, StExecuteI:     state_d = StAluWb;
            StExecuteM: begin
                if (at_term) state_d = StAluWb;
            end
            StFault:    state_d = StFault;
            default:    state_d = StFetch;
        endcase
        if (timeout_hit) state_d = StFault;
    end

    // Moore control outputs, except the FETCH completion strobes.
    always_comb begin
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        MulBusy   = 1'b0;
        Fault     = 1'b0;
        case (state_q)
            StFetch: begin
                MemReq    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                // MemReady is ignored while reset is held.
                NextPC    = MemReady & reset;
                IRWrite   = MemReady & reset;
            end
            StDecode: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            StMemAdr: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
            end
            StMemRead: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALU;
            end
            StMemWb: begin
                RegW      = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = RES_DATA;
            end
            StMemWrite: begin
                MemReq    = 1'b1;
                MemW      = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALU;
            end
            StExecuteR: begin
                ALUSrcB   = SRCB_REG;
                ALUOp     = 1'b1;
                ResultSrc = RES_ALU;
            end
            StExecuteI: begin
                ALUSrcB   = SRCB_IMM;
                ALUOp     = 1'b1;
                ResultSrc = RES_ALU;
            end
            StExecuteM: begin
                MulBusy   = 1'b1;
                ALUSrcB   = SRCB_REG;
                ALUOp     = 1'b1;
                ResultSrc = RES_ALU;
            end
            StAluWb: begin
                RegW      = 1'b1;
                ResultSrc = RES_ALU_OUT;
                ALUOp     = 1'b1;
            end
            StBranch: begin
                Branch    = 1'b1;
                ALUSrcA   = SRCA_ALU_OUT;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
            end
            StFault: begin
                Fault = 1'b1;
            end
            default: begin
                Fault = 1'b0;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_mainfsm_ws.sv
// Randomized and directed bench for mainfsm_ws; two instances with different parameters
// share one stimulus stream and are checked against a table-driven reference model.
module tb_mainfsm_ws;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       IsMul = 1'b0;
    logic       MemReady = 1'b0;

    logic       a_MemReq, a_IRWrite, a_AdrSrc, a_NextPC, a_RegW, a_MemW, a_Branch;
    logic       a_ALUOp, a_MulBusy, a_Fault;
    logic [1:0] a_ALUSrcA, a_ALUSrcB, a_ResultSrc;
    logic [3:0] a_State;
    logic       b_MemReq, b_IRWrite, b_AdrSrc, b_NextPC, b_RegW, b_MemW, b_Branch;
    logic       b_ALUOp, b_MulBusy, b_Fault;
    logic [1:0] b_ALUSrcA, b_ALUSrcB, b_ResultSrc;
    logic [3:0] b_State;

    logic [15:0] out_a, out_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state for each instance: abstract state number and stall/mul count.
    int ma_st = 0, ma_cnt = 0, mb_st = 0, mb_cnt = 0;
    int obs_a_state, obs_b_state;
    logic obs_a_mulbusy;

    localparam int A_TMO = 15, A_MUL = 1, A_MULC = 4;
    localparam int B_TMO = 0,  B_MUL = 0, B_MULC = 2;

    always #5 clk = ~clk;

    mainfsm_ws #(
        .MEM_TIMEOUT (A_TMO),
        .SUPPORT_MUL (A_MUL),
        .MUL_CYCLES  (A_MULC),
        .CNT_W       (4)
    ) dut_a (
        .clk (clk), .reset (reset), .Op (Op), .Funct (Funct), .IsMul (IsMul),
        .MemReady (MemReady), .MemReq (a_MemReq), .IRWrite (a_IRWrite), .AdrSrc (a_AdrSrc),
        .ALUSrcA (a_ALUSrcA), .ALUSrcB (a_ALUSrcB), .ResultSrc (a_ResultSrc),
        .NextPC (a_NextPC), .RegW (a_RegW), .MemW (a_MemW), .Branch (a_Branch),
        .ALUOp (a_ALUOp), .MulBusy (a_MulBusy), .Fault (a_Fault), .State (a_State)
    );

    mainfsm_ws #(
        .MEM_TIMEOUT (B_TMO),
        .SUPPORT_MUL (B_MUL),
        .MUL_CYCLES  (B_MULC),
        .CNT_W       (4)
    ) dut_b (
        .clk (clk), .reset (reset), .Op (Op), .Funct (Funct), .IsMul (IsMul),
        .MemReady (MemReady), .MemReq (b_MemReq), .IRWrite (b_IRWrite), .AdrSrc (b_AdrSrc),
        .ALUSrcA (b_ALUSrcA), .ALUSrcB (b_ALUSrcB), .ResultSrc (b_ResultSrc),
        .NextPC (b_NextPC), .RegW (b_RegW), .MemW (b_MemW), .Branch (b_Branch),
        .ALUOp (b_ALUOp), .MulBusy (b_MulBusy), .Fault (b_Fault), .State (b_State)
    );

    assign out_a = {a_MemReq, a_IRWrite, a_AdrSrc, a_ALUSrcA, a_ALUSrcB, a_ResultSrc,
                    a_NextPC, a_RegW, a_MemW, a_Branch, a_ALUOp, a_MulBusy, a_Fault};
    assign out_b = {b_MemReq, b_IRWrite, b_AdrSrc, b_ALUSrcA, b_ALUSrcB, b_ResultSrc,
                    b_NextPC, b_RegW, b_MemW, b_Branch, b_ALUOp, b_MulBusy, b_Fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word per state, straight from the output table.
    function automatic logic [15:0] exp_out(input int st, input logic rdy);
        logic mreq, irw, adr, npc, rw, mw, br, aop, mb, flt;
        logic [1:0] sa, sb, rs;
        {mreq, irw, adr, npc, rw, mw, br, aop, mb, flt} = '0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (st)
            0:  begin mreq = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; npc = rdy; irw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            2:  begin sa = 2'b00; sb = 2'b01; rs = 2'b10; end
            3:  begin mreq = 1; adr = 1; rs = 2'b10; end
            4:  begin rw = 1; adr = 1; rs = 2'b01; end
            5:  begin mreq = 1; mw = 1; adr = 1; rs = 2'b10; end
            6:  begin sb = 2'b00; aop = 1; rs = 2'b10; end
            7:  begin sb = 2'b01; aop = 1; rs = 2'b10; end
            8:  begin rw = 1; rs = 2'b00; aop = 1; end
            9:  begin br = 1; sa = 2'b10; sb = 2'b01; rs = 2'b10; end
            10: begin mb = 1; sb = 2'b00; aop = 1; rs = 2'b10; end
            11: begin flt = 1; end
            default: ;
        endcase
        return {mreq, irw, adr, sa, sb, rs, npc, rw, mw, br, aop, mb, flt};
    endfunction

    function automatic int nxt_state(input int st, input int cnt, input logic [1:0] op,
                                     input logic [5:0] f, input logic im, input logic rdy,
                                     input int sup, input int tmo, input int mulc);
        int n;
        case (st)
            0:  n = rdy ? 1 : 0;
            1: begin
                if (op == 2'd0) n = f[5] ? 7 : ((im && sup != 0) ? 10 : 6);
                else if (op == 2'd1) n = 2;
                else if (op == 2'd2) n = 9;
                else n = 11;
            end
            2:  n = f[0] ? 5 : 3;
            3:  n = rdy ? 4 : 3;
            5:  n = rdy ? 0 : 5;
            4, 8, 9: n = 0;
            6, 7: n = 8;
            10: n = (cnt == mulc - 1) ? 8 : 10;
            11: n = 11;
            default: n = 0;
        endcase
        if ((st == 0 || st == 3 || st == 5) && !rdy && tmo > 0 && cnt == tmo - 1) n = 11;
        return n;
    endfunction

    function automatic int nxt_cnt(input int st, input int n, input int cnt, input logic rdy);
        if (n != st) return 0;
        if (((st == 0 || st == 3 || st == 5) && !rdy) || st == 10) return cnt + 1;
        return cnt;
    endfunction

    // Advance both models with the inputs that were present at the clock edge.
    task automatic step_models();
        int n;
        n = nxt_state(ma_st, ma_cnt, Op, Funct, IsMul, MemReady, A_MUL, A_TMO, A_MULC);
        ma_cnt = nxt_cnt(ma_st, n, ma_cnt, MemReady);
        ma_st = n;
        n = nxt_state(mb_st, mb_cnt, Op, Funct, IsMul, MemReady, B_MUL, B_TMO, B_MULC);
        mb_cnt = nxt_cnt(mb_st, n, mb_cnt, MemReady);
        mb_st = n;
    endtask

    // One clock: drive inputs after the falling edge, check, then take the rising edge.
    task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic im,
                         input logic rdy);
        @(negedge clk);
        Op = op; Funct = f; IsMul = im; MemReady = rdy;
        #1;
        check("a_state", a_State, ma_st);
        check("a_out", out_a, exp_out(ma_st, rdy));
        check("b_state", b_State, mb_st);
        check("b_out", out_b, exp_out(mb_st, rdy));
        obs_a_state = a_State;
        obs_b_state = b_State;
        obs_a_mulbusy = a_MulBusy;
        @(posedge clk);
        step_models();
    endtask

    // Asynchronous reset asserted between clock edges, with MemReady high to show it is ignored.
    task automatic do_reset();
        #2;
        MemReady = 1'b1;
        reset = 1'b0;
        #2;
        ma_st = 0; ma_cnt = 0; mb_st = 0; mb_cnt = 0;
        check("rst_a_state", a_State, 0);
        check("rst_a_out", out_a, exp_out(0, 1'b0));
        check("rst_b_state", b_State, 0);
        check("rst_b_out", out_b, exp_out(0, 1'b0));
        @(negedge clk);
        MemReady = 1'b0; Op = 2'b00; Funct = 6'd0; IsMul = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        step_models();
    endtask

    initial begin
        int cnt;
        int seen;
        int thr;
        int exp_dp[4];
        exp_dp = '{0, 1, 6, 8};

        #1;
        do_reset();

        // Data-processing register op with MemReady held high.
        for (int i = 0; i < 4; i++) begin
            apply(2'b00, 6'b000100, 1'b0, 1'b1);
            check("dp_seq", obs_a_state, exp_dp[i]);
        end
        apply(2'b00, 6'b000100, 1'b0, 1'b1);
        check("dp_back_fetch", obs_a_state, 0);

        // Load with three stall cycles in MEMREAD.
        do_reset();
        apply(2'b01, 6'b000000, 1'b0, 1'b1);
        apply(2'b01, 6'b000000, 1'b0, 1'b1);
        apply(2'b01, 6'b000000, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            apply(2'b01, 6'b000000, 1'b0, (i == 3));
            if (obs_a_state == 3) cnt++;
        end
        check("ld_memread_cycles", cnt, 4);
        apply(2'b01, 6'b000000, 1'b0, 1'b1);
        check("ld_memwb", obs_a_state, 4);

        // Store that never completes: instance A must fault after 15 MEMWRITE cycles.
        do_reset();
        for (int i = 0; i < 3; i++) apply(2'b01, 6'b000001, 1'b0, 1'b1);
        cnt = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            apply(2'b01, 6'b000001, 1'b0, 1'b0);
            if (obs_a_state == 5) cnt++;
            else if (obs_a_state == 11) begin seen = 1; break; end
        end
        check("st_timeout_cycles", cnt, 15);
        check("st_fault_seen", seen, 1);
        for (int i = 0; i < 3; i++) apply(2'b01, 6'b000001, 1'b0, 1'b1);
        check("st_fault_sticky", obs_a_state, 11);
        do_reset();

        // Timeout race: completion on the 15th MEMWRITE cycle wins.
        for (int i = 0; i < 3; i++) apply(2'b01, 6'b000001, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) apply(2'b01, 6'b000001, 1'b0, 1'b0);
        apply(2'b01, 6'b000001, 1'b0, 1'b1);
        check("race_last_wait", obs_a_state, 5);
        apply(2'b00, 6'b000000, 1'b0, 1'b0);
        check("race_fetch", obs_a_state, 0);

        // Multiply: A spends exactly MUL_CYCLES in EXECUTEM, B takes EXECUTER.
        do_reset();
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        apply(2'b00, 6'b000000, 1'b0, 1'b1);
        check("b_no_mul", obs_b_state, 6);
        cnt = obs_a_mulbusy ? 1 : 0;
        for (int i = 0; i < 20 && obs_a_state != 8; i++) begin
            apply(2'b00, 6'b000000, 1'b0, 1'b1);
            if (obs_a_mulbusy) cnt++;
        end
        check("mul_busy_cycles", cnt, A_MULC);
        check("mul_then_aluwb", obs_a_state, 8);

        // Fetch stall, then reset mid-multiply, then a full multiply to show the count restarted.
        do_reset();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            apply(2'b00, 6'b000000, 1'b1, 1'b0);
            if (a_NextPC || a_IRWrite) seen++;
        end
        check("fetch_stall_strobes", seen, 0);
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        apply(2'b00, 6'b000000, 1'b0, 1'b1);
        check("mul_before_rst", obs_a_state, 10);
        do_reset();
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        apply(2'b00, 6'b000000, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            apply(2'b00, 6'b000000, 1'b0, 1'b1);
            if (obs_a_mulbusy) cnt++;
            if (obs_a_state == 8) break;
        end
        check("mul_after_rst_cycles", cnt, A_MULC);

        // Randomized traffic with varying memory readiness and occasional resets.
        thr = 90;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: thr = 90;
                    1: thr = 50;
                    default: thr = 5;
                endcase
            end
            op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            f = 6'($urandom);
            apply(op, f, 1'($urandom), ($urandom_range(0, 99) < thr));
            if ($urandom_range(0, 299) == 0 ||
                ((ma_st == 11 || mb_st == 11) && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
